// File: rtl/common.sv
// common: types and constants shared by the fetch stage and its FIFO.
package common;

    typedef enum logic [1:0] {FETCH_OK, FETCH_MISALIGNED, FETCH_ACCESS} fetch_fault_t;

    typedef struct packed {
        logic [31:0]  instr;
        logic [31:0]  pc;
        fetch_fault_t fault;
    } if_entry_t;

    typedef enum logic {ST_FETCH, ST_HALT} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched entries; pointers carry an extra wrap bit.
module fetch_fifo
    import common::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  if_entry_t   wdata,
    output if_entry_t   rdata,
    output logic [AW:0] count,
    output logic        empty
);
    if_entry_t   mem [DEPTH];
    logic [AW:0] wptr, rptr;

    assign count = wptr - rptr;
    assign empty = wptr == rptr;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with in-order response buffering and redirect flush.
module fetch_unit
    import common::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [1:0]  if_fault
);
    localparam int AW = $clog2(DEPTH);

    fetch_state_t state;
    logic [31:0]  fetch_pc, resp_pc;
    logic [AW:0]  outstanding, discard, out_nxt, count;
    logic         misal, accept, keep, push, pop, empty;
    if_entry_t    wdata, head;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect_valid),
        .wdata(wdata), .rdata(head), .count(count), .empty(empty)
    );

    // Reserving a slot per outstanding request keeps the FIFO from ever overflowing.
    assign imem_req_valid = !rst && state == ST_FETCH && !redirect_valid &&
                            ((AW+2)'(count) + (AW+2)'(outstanding)) < (AW+2)'(DEPTH);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req_valid && imem_req_ready;
    assign keep      = imem_resp_valid && !redirect_valid && discard == '0;
    assign push      = !redirect_valid && (keep || misal);
    assign out_nxt   = outstanding + (AW+1)'(accept) - (AW+1)'(imem_resp_valid);
    assign wdata     = misal ? '{NOP_INSTR, resp_pc, FETCH_MISALIGNED}
                             : '{imem_resp_err ? NOP_INSTR : imem_resp_data, resp_pc,
                                 imem_resp_err ? FETCH_ACCESS : FETCH_OK};

    assign if_valid = !empty && !redirect_valid;
    assign pop      = if_valid && id_ready;
    assign if_instr = empty ? '0 : head.instr;
    assign if_pc    = empty ? '0 : head.pc;
    assign if_fault = empty ? '0 : head.fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            misal       <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            misal       <= 1'b0;
            if (redirect_valid) begin
                state    <= redirect_pc[1:0] == 2'b00 ? ST_FETCH : ST_HALT;
                misal    <= redirect_pc[1:0] != 2'b00;
                discard  <= out_nxt;
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (imem_resp_valid && discard != '0) discard <= discard - 1'b1;
                if (keep) resp_pc <= resp_pc + 32'd4;
                // A faulting fetch halts; everything still in flight behind it is dead.
                if (keep && imem_resp_err) begin
                    state   <= ST_HALT;
                    discard <= out_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a queue-based in-order memory.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0, imem_resp_err = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0, id_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [1:0]  if_fault;

    logic        hold = 1'b0, acc = 1'b0;
    logic [31:0] acc_addr = '0, err_addr = '1;
    logic [31:0] q[$];
    int          n_cmp = 0, n_bad = 0;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    // Memory: capture accepts mid-cycle, answer in order one cycle later unless held.
    initial forever begin
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            imem_resp_valid = 1'b0;
        end else begin
            if (imem_resp_valid) void'(q.pop_front());
            if (acc) q.push_back(acc_addr);
            imem_resp_valid = !hold && q.size() > 0;
            imem_resp_data  = q.size() > 0 ? (32'hCAFE_0000 | q[0]) : '0;
            imem_resp_err   = q.size() > 0 && q[0] == err_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #3;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        nxt();
        rst = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        hold = 1'b0;
        err_addr = '1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        nxt();
        neg();
        chk("rst req_valid", 32'(imem_req_valid), 0);
        chk("rst if_valid", 32'(if_valid), 0);
        chk("rst addr", imem_addr, 32'h0);

        // Streaming from reset
        reset_dut();
        id_ready = 1'b1;
        neg();
        chk("s1 req0", 32'(imem_req_valid), 1);
        chk("s1 addr0", imem_addr, 32'h0);
        nxt(); neg();
        chk("s1 ifv c1", 32'(if_valid), 0);
        chk("s1 addr1", imem_addr, 32'h4);
        for (int k = 0; k < 4; k++) begin
            nxt(); neg();
            chk("s1 ifv", 32'(if_valid), 1);
            chk("s1 pc", if_pc, 32'(4 * k));
            chk("s1 instr", if_instr, 32'hCAFE_0000 | 32'(4 * k));
        end

        // Back-pressure fills exactly DEPTH slots
        reset_dut();
        id_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            neg();
            if (imem_req_valid && imem_req_ready) n_acc++;
            nxt();
        end
        chk("s2 accepted", 32'(n_acc), 4);
        neg();
        chk("s2 req held", 32'(imem_req_valid), 0);
        nxt();
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("s2 ifv", 32'(if_valid), 1);
            chk("s2 pc", if_pc, 32'(4 * k));
            nxt();
        end

        // Redirect with three fetches in flight
        reset_dut();
        id_ready = 1'b1;
        hold = 1'b1;
        nxt(); nxt(); nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        hold = 1'b0;
        neg();
        chk("s3 req redir", 32'(imem_req_valid), 0);
        chk("s3 ifv redir", 32'(if_valid), 0);
        nxt();
        redirect_valid = 1'b0;
        neg();
        chk("s3 req after", 32'(imem_req_valid), 1);
        chk("s3 addr after", imem_addr, 32'h100);
        chk("s3 ifv c4", 32'(if_valid), 0);
        for (int k = 0; k < 3; k++) begin
            nxt(); neg();
            chk("s3 no stale", 32'(if_valid), 0);
        end
        nxt(); neg();
        chk("s3 ifv new", 32'(if_valid), 1);
        chk("s3 pc new", if_pc, 32'h100);
        chk("s3 instr new", if_instr, 32'hCAFE_0100);

        // Misaligned redirect halts until a good redirect
        reset_dut();
        id_ready = 1'b1;
        nxt(); nxt(); nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        neg();
        chk("s4 req redir", 32'(imem_req_valid), 0);
        nxt();
        redirect_valid = 1'b0;
        neg();
        chk("s4 ifv c4", 32'(if_valid), 0);
        chk("s4 req c4", 32'(imem_req_valid), 0);
        nxt(); neg();
        chk("s4 ifv mis", 32'(if_valid), 1);
        chk("s4 pc mis", if_pc, 32'h102);
        chk("s4 fault mis", 32'(if_fault), 1);
        chk("s4 instr mis", if_instr, 32'h13);
        nxt(); neg();
        chk("s4 ifv halt", 32'(if_valid), 0);
        chk("s4 req halt", 32'(imem_req_valid), 0);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        neg();
        chk("s4 req resume redir", 32'(imem_req_valid), 0);
        nxt();
        redirect_valid = 1'b0;
        neg();
        chk("s4 req resume", 32'(imem_req_valid), 1);
        chk("s4 addr resume", imem_addr, 32'h200);

        // Access fault on 0x8 with 0xC outstanding
        reset_dut();
        err_addr = 32'h8;
        id_ready = 1'b1;
        nxt(); nxt(); neg();
        chk("s5 pc0", if_pc, 32'h0);
        nxt(); neg();
        chk("s5 pc4", if_pc, 32'h4);
        chk("s5 fault4", 32'(if_fault), 0);
        chk("s5 addrC", imem_addr, 32'hC);
        chk("s5 reqC", 32'(imem_req_valid), 1);
        nxt(); neg();
        chk("s5 ifv err", 32'(if_valid), 1);
        chk("s5 pc err", if_pc, 32'h8);
        chk("s5 fault err", 32'(if_fault), 2);
        chk("s5 instr err", if_instr, 32'h13);
        chk("s5 req halt", 32'(imem_req_valid), 0);
        nxt(); neg();
        chk("s5 C dropped", 32'(if_valid), 0);
        nxt(); neg();
        chk("s5 still halt", 32'(if_valid), 0);
        chk("s5 req still", 32'(imem_req_valid), 0);

        // Redirect with pop and response in the same cycle, then reset mid-burst
        reset_dut();
        id_ready = 1'b0;
        nxt(); nxt(); nxt(); nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        id_ready = 1'b1;
        neg();
        chk("s6 ifv redir", 32'(if_valid), 0);
        chk("s6 req redir", 32'(imem_req_valid), 0);
        nxt();
        redirect_valid = 1'b0;
        neg();
        chk("s6 fifo empty", 32'(if_valid), 0);
        chk("s6 req", 32'(imem_req_valid), 1);
        chk("s6 addr", imem_addr, 32'h40);
        nxt(); nxt(); neg();
        chk("s6 ifv new", 32'(if_valid), 1);
        chk("s6 pc new", if_pc, 32'h40);
        nxt();
        rst = 1'b1;
        neg();
        chk("s6 rst req", 32'(imem_req_valid), 0);
        chk("s6 rst ifv", 32'(if_valid), 0);
        chk("s6 rst instr", if_instr, 32'h0);
        chk("s6 rst pc", if_pc, 32'h0);
        chk("s6 rst fault", 32'(if_fault), 0);
        chk("s6 rst addr", imem_addr, 32'h0);
        nxt();
        rst = 1'b0;
        neg();
        chk("s6 restart req", 32'(imem_req_valid), 1);
        chk("s6 restart addr", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
